// File: rtl/fft_stage_buffer_if.sv
// Data/handshake bundle between the butterfly array and fft_stage_buffer.
// The master drives the stage results and the sink handshake. The slave returns feedback and the held final result.
interface fft_stage_buffer_if #(
  parameter int WIDTH  = 16,
  parameter int POINTS = 32,
  parameter int STAGES = 5
);
  localparam int SW = $clog2(STAGES);
  localparam int DW = WIDTH * POINTS;

  logic          enable;
  logic          abort;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_imag;
  logic [DW-1:0] feedback_real;
  logic [DW-1:0] feedback_imag;
  logic [SW-1:0] stage_idx;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_imag;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic          clr_overrun;

  modport master (
    output enable, abort, in_real, in_imag, out_ready, clr_overrun,
    input  feedback_real, feedback_imag, stage_idx, out_real, out_imag, out_valid, overrun
  );

  modport slave (
    input  enable, abort, in_real, in_imag, out_ready, clr_overrun,
    output feedback_real, feedback_imag, stage_idx, out_real, out_imag, out_valid, overrun
  );
endinterface

// File: rtl/fft_stage_buffer.sv
// Per-stage register and final-result holder for an iterative FFT. It counts butterfly passes and holds the last pass for a valid/ready sink.
// Define FFT_STAGE_BUFFER_BITREV_EN to store the final result in natural frequency order (bit-reversed capture).
module fft_stage_buffer #(
  parameter int WIDTH  = 16,
  parameter int POINTS = 32,
  parameter int STAGES = 5
) (
  input  logic             clk,
  input  logic             rst,
  fft_stage_buffer_if.slave bus
);
  localparam int SW = $clog2(STAGES);
  localparam int DW = WIDTH * POINTS;
  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

  logic [SW-1:0] r_stage_idx;
  logic [DW-1:0] r_fb_real;
  logic [DW-1:0] r_fb_imag;
  logic [DW-1:0] r_out_real;
  logic [DW-1:0] r_out_imag;
  logic          r_out_valid;
  logic          r_overrun;

  logic          w_accept;
  logic          w_final;
  logic          w_capture;
  logic          w_lost;
  logic [DW-1:0] w_cap_real;
  logic [DW-1:0] w_cap_imag;

  assign w_accept  = bus.enable && !bus.abort;
  assign w_final   = w_accept && (r_stage_idx == LAST_STAGE);
  // The sink's slot is free if it is empty or is being drained in this same cycle.
  assign w_capture = w_final && (!r_out_valid || bus.out_ready);
  assign w_lost    = w_final && r_out_valid && !bus.out_ready;

`ifdef FFT_STAGE_BUFFER_BITREV_EN
  function automatic int bitrev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < STAGES; b++) begin
      r[b] = k[STAGES-1-b];
    end
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < POINTS; gi++) begin : g_rev
      localparam int RI = bitrev(gi);
      assign w_cap_real[RI*WIDTH +: WIDTH] = bus.in_real[gi*WIDTH +: WIDTH];
      assign w_cap_imag[RI*WIDTH +: WIDTH] = bus.in_imag[gi*WIDTH +: WIDTH];
    end
  endgenerate
`else
  assign w_cap_real = bus.in_real;
  assign w_cap_imag = bus.in_imag;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage_idx <= '0;
      r_fb_real   <= '0;
      r_fb_imag   <= '0;
      r_out_real  <= '0;
      r_out_imag  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (bus.abort) begin
        r_stage_idx <= '0;
      end else if (bus.enable) begin
        r_stage_idx <= w_final ? '0 : r_stage_idx + SW'(1);
      end

      if (w_accept) begin
        r_fb_real <= bus.in_real;
        r_fb_imag <= bus.in_imag;
      end

      // A new capture takes priority over a simultaneous drain so no handshake is lost.
      if (w_capture) begin
        r_out_real  <= w_cap_real;
        r_out_imag  <= w_cap_imag;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_lost) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.stage_idx     = r_stage_idx;
  assign bus.feedback_real = r_fb_real;
  assign bus.feedback_imag = r_fb_imag;
  assign bus.out_real      = r_out_real;
  assign bus.out_imag      = r_out_imag;
  assign bus.out_valid     = r_out_valid;
  assign bus.overrun       = r_overrun;
endmodule

// File: doc/fft_stage_buffer.md
FFT_STAGE_BUFFER -- requirements
Module: fft_stage_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of each real/imag sample.
REQ-002 SHALL have parameter POINTS, default 32, samples per transform (power of 2, 4..1024).
REQ-003 SHALL have parameter STAGES, default 5, butterfly passes per transform (log2(POINTS)); SW = clog2(STAGES).
REQ-004 SHALL have port clk input 1, sole clock, rising-edge.
REQ-005 SHALL have port rst input 1, asynchronous active-high reset.
REQ-006 SHALL have port enable input 1, stage result present on in_real/in_imag this cycle.
REQ-007 SHALL have port abort input 1, discard the transform in progress.
REQ-008 SHALL have ports in_real, in_imag input WIDTH*POINTS, butterfly stage result; sample k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have ports feedback_real, feedback_imag output WIDTH*POINTS, registered stage result returned to the butterfly array.
REQ-010 SHALL have port stage_idx output SW, count of stages completed in the current transform.
REQ-011 SHALL have ports out_real, out_imag output WIDTH*POINTS, held final FFT result.
REQ-012 SHALL have port out_valid output 1 and port out_ready input 1, valid/ready handshake on out_*.
REQ-013 SHALL have port overrun output 1, sticky flag for a lost final result.
REQ-014 SHALL have port clr_overrun input 1, synchronous clear of overrun.

Function
REQ-015 SHALL load feedback_* from in_* on every clk edge with enable=1 and abort=0; otherwise hold.
REQ-016 SHALL increment stage_idx on each accepted enable while stage_idx < STAGES-1.
REQ-017 SHALL treat the enable with stage_idx = STAGES-1 as final: stage_idx wraps to 0, final result captured per REQ-018.
REQ-018 On final enable: if out_valid=0 or out_ready=1 in the same cycle, SHALL load out_* from in_* and set out_valid=1 next cycle; else SHALL leave out_* unchanged and set overrun=1.
REQ-019 SHALL clear out_valid on out_valid=1 and out_ready=1 when no capture occurs in that cycle; capture takes priority (out_valid stays 1 with new data).
REQ-020 SHALL hold out_* stable whenever out_valid=1 and out_ready=0.
REQ-021 abort=1 SHALL set stage_idx to 0 and block feedback loading and final capture that cycle (abort wins over enable); out_*, out_valid, overrun unaffected.
REQ-022 Latency: feedback_* and out_* SHALL reflect in_* exactly one clk after the loading edge; no combinational path from in_* to any output.
REQ-023 overrun SHALL remain 1 until clr_overrun=1 or rst; a simultaneous set and clr_overrun SHALL leave overrun=1.
REQ-024 enable with out_ready toggling SHALL never cause duplicate or dropped out_valid handshakes other than per REQ-018.

Reset
REQ-025 rst=1 SHALL immediately force feedback_*, out_* to 0, stage_idx to 0, out_valid to 0, overrun to 0, independent of clk.
REQ-026 Reset asserted mid-transform SHALL discard partial progress; the first enable after release SHALL be counted as stage 0.

Configuration
REQ-027 With macro FFT_STAGE_BUFFER_BITREV_EN defined, final capture SHALL store input sample k at output index bitrev(k, STAGES) so out_* is in natural frequency order; feedback_* is never reordered.
REQ-028 Without FFT_STAGE_BUFFER_BITREV_EN, out_* sample k SHALL equal captured in_* sample k.

Verification (WIDTH=16, POINTS=8, STAGES=3)
REQ-029 Three enables with in_real sample k = 0x0100+k, out_ready=1 -> stage_idx 0,1,2,0; out_valid=1 one cycle after third enable; out_real sample k = 0x0100+k (macro off) or sample bitrev(k) (macro on, e.g. out index 1 = 0x0104).
REQ-030 Final result held with out_ready=0, second transform completes -> overrun=1, out_* keeps first result; clr_overrun pulse -> overrun=0.
REQ-031 Final enable with out_valid=1 and out_ready=1 same cycle -> out_* updated to new data, out_valid stays 1, overrun=0.
REQ-032 enable and abort together at stage_idx=1 -> stage_idx=0, feedback_* unchanged, out_valid unchanged.
REQ-033 rst pulsed asynchronously between clk edges at stage_idx=2 with out_valid=1 -> all outputs 0 before next edge; next three enables produce one complete result.
